controle_entrada: RTL and testbench

Input-instruction controller for the lab processor. It owns the board push-button and switch bank and sequences them for the processor. When the control unit issues an input request, the block stalls the processor and waits for one clean button press. It then latches the switch value and hands it over with a one-cycle valid strobe. Presses outside a request are discarded.

---
 rtl/controle_entrada.sv | 124 ++++++++++++
 tb/tb_controle_entrada.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_entrada.sv
`default_nettype none
// ============================================================================
// Module   : controle_entrada
// Purpose  : Input-instruction controller. Stalls the processor on request,
//            debounces one fresh button press and delivers the switch value.
// Revision : 1.0 - initial release
// ============================================================================
module controle_entrada #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  botaoPlaca,
    input  logic [DATA_WIDTH-1:0] chaves,
    input  logic                  pedidoEntrada,
    output logic [DATA_WIDTH-1:0] dadoEntrada,
    output logic                  entradaPronta,
    output logic                  pausa,
    output logic                  aguardando
);

    localparam int                CONT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        SOLTAR  = 3'd1,
        ESPERA  = 3'd2,
        ENTREGA = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t               estado;
    logic                  s1;
    logic                  s2;
    logic [DATA_WIDTH-1:0] chaves_s1;
    logic [DATA_WIDTH-1:0] chaves_s2;
    logic                  estavel;
    logic                  estavel_d;
    logic                  evento;
    logic [CONT_W-1:0]     cont;

    // Switches share the button's synchronizer depth so the captured value
    // lines up with the press that selected it.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            chaves_s1 <= '0;
            chaves_s2 <= '0;
            estavel   <= 1'b0;
            estavel_d <= 1'b0;
            evento    <= 1'b0;
            cont      <= '0;
        end else begin
            s1        <= botaoPlaca;
            s2        <= s1;
            chaves_s1 <= chaves;
            chaves_s2 <= chaves_s1;
            if (s2 == estavel) begin
                cont <= '0;
            end else if (cont == CONT_MAX) begin
                estavel <= s2;
                cont    <= '0;
            end else begin
                cont <= cont + CONT_W'(1);
            end
            estavel_d <= estavel;
            evento    <= estavel & ~estavel_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= OCIOSO;
            dadoEntrada   <= '0;
            entradaPronta <= 1'b0;
        end else begin
            entradaPronta <= 1'b0;
            case (estado)
                OCIOSO: begin
                    // A press already in progress at request time must be
                    // released first, so held buttons go through SOLTAR.
                    if (pedidoEntrada) begin
                        estado <= estavel ? SOLTAR : ESPERA;
                    end
                end
                SOLTAR: begin
                    if (!pedidoEntrada) begin
                        estado <= OCIOSO;
                    end else if (!estavel) begin
                        estado <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (!pedidoEntrada) begin
                        estado <= OCIOSO;
                    end else if (evento) begin
                        dadoEntrada   <= chaves_s2;
                        entradaPronta <= 1'b1;
                        estado        <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    estado <= FIM;
                end
                FIM: begin
                    if (!pedidoEntrada) begin
                        estado <= OCIOSO;
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign aguardando = (estado == SOLTAR) || (estado == ESPERA);
    assign pausa      = aguardando || ((estado == OCIOSO) && pedidoEntrada);

endmodule
`default_nettype wire

// File: tb/tb_controle_entrada.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_entrada
// Purpose  : Self-checking bench: directed scenarios plus random stimulus
//            compared every cycle against a sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_entrada;

    localparam int W = 16;
    localparam int D = 4;

    localparam int M_IDLE    = 0;
    localparam int M_RELEASE = 1;
    localparam int M_ARMED   = 2;
    localparam int M_STROBE  = 3;
    localparam int M_DONE    = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         botaoPlaca;
    logic [W-1:0] chaves;
    logic         pedidoEntrada;
    logic [W-1:0] dadoEntrada;
    logic         entradaPronta;
    logic         pausa;
    logic         aguardando;

    int tests   = 0;
    int fails   = 0;
    int strobes = 0;
    int cyc     = 0;

    controle_entrada #(.DATA_WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clock         (clk),
        .reset         (reset),
        .botaoPlaca    (botaoPlaca),
        .chaves        (chaves),
        .pedidoEntrada (pedidoEntrada),
        .dadoEntrada   (dadoEntrada),
        .entradaPronta (entradaPronta),
        .pausa         (pausa),
        .aguardando    (aguardando)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: raw button history window, switch delay line and a
    // transaction-level request tracker.
    bit           hist [0:D];
    logic [W-1:0] csync [0:1];
    bit           m_est, m_estd, m_ev, m_pronta, m_started;
    int           m_mode;
    logic [W-1:0] m_dado;

    always @(posedge clk) begin
        bit     flip;
        bit     ev_n;
        int     mode_n;
        cyc++;
        if (reset === 1'b1) begin
            for (int i = 0; i <= D; i++) hist[i] = 1'b0;
            csync[0] = '0;
            csync[1] = '0;
            m_est = 0; m_estd = 0; m_ev = 0; m_pronta = 0;
            m_mode = M_IDLE; m_dado = '0; m_started = 1;
        end else if (m_started) begin
            // Level flips once the synchronized button has shown the
            // opposite level for D consecutive samples.
            flip = 1;
            for (int i = 1; i <= D; i++) if (hist[i] == m_est) flip = 0;
            mode_n   = m_mode;
            m_pronta = 0;
            case (m_mode)
                M_IDLE:    if (pedidoEntrada) mode_n = m_est ? M_RELEASE : M_ARMED;
                M_RELEASE: if (!pedidoEntrada) mode_n = M_IDLE;
                           else if (!m_est) mode_n = M_ARMED;
                M_ARMED:   if (!pedidoEntrada) mode_n = M_IDLE;
                           else if (m_ev) begin
                               m_dado = csync[1];
                               m_pronta = 1;
                               mode_n = M_STROBE;
                           end
                M_STROBE:  mode_n = M_DONE;
                default:   if (!pedidoEntrada) mode_n = M_IDLE;
            endcase
            m_mode = mode_n;
            ev_n   = m_est & ~m_estd;
            m_estd = m_est;
            m_ev   = ev_n;
            if (flip) m_est = ~m_est;
            for (int i = D; i >= 1; i--) hist[i] = hist[i-1];
            hist[0]  = botaoPlaca;
            csync[1] = csync[0];
            csync[0] = chaves;
        end
    end

    always @(negedge clk) begin
        bit waiting;
        if (entradaPronta === 1'b1) strobes++;
        if (m_started) begin
            waiting = (m_mode == M_RELEASE) || (m_mode == M_ARMED);
            chk("entradaPronta", {31'd0, entradaPronta}, {31'd0, m_pronta});
            chk("dadoEntrada", {16'd0, dadoEntrada}, {16'd0, m_dado});
            chk("aguardando", {31'd0, aguardando}, {31'd0, waiting});
            chk("pausa", {31'd0, pausa},
                {31'd0, waiting || (m_mode == M_IDLE && pedidoEntrada)});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int hold, input int after);
        botaoPlaca = 1'b1;
        tick(hold);
        botaoPlaca = 1'b0;
        tick(after);
    endtask

    initial begin
        int s0;
        int t0;
        int t1;
        reset = 1'b1; botaoPlaca = 1'b0; chaves = '0; pedidoEntrada = 1'b0;
        tick(3);
        reset = 1'b0;
        #1;
        chk("reset_dado", {16'd0, dadoEntrada}, 32'h0);
        chk("reset_pronta", {31'd0, entradaPronta}, 32'h0);
        chk("reset_aguardando", {31'd0, aguardando}, 32'h0);
        chk("reset_pausa", {31'd0, pausa}, 32'h0);
        tick(1);

        // Clean press: request stalls at once, strobe 7 edges after the press.
        pedidoEntrada = 1'b1; chaves = 16'h00A5;
        #1;
        chk("pausa_immediate", {31'd0, pausa}, 32'h1);
        tick(D + 3);
        s0 = strobes;
        botaoPlaca = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        t1 = t0 + 100;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (entradaPronta === 1'b1) begin
                t1 = cyc;
                break;
            end
        end
        chk("press_latency", t1 - t0, 32'd7);
        chk("press_dado", {16'd0, dadoEntrada}, 32'h00A5);
        chk("pausa_entrega", {31'd0, pausa}, 32'h0);
        tick(2);
        botaoPlaca = 1'b0;
        tick(6);
        chk("press_single_strobe", strobes - s0, 32'd1);
        pedidoEntrada = 1'b0;
        tick(3);

        // Bouncing button then a steady hold: exactly one delivery.
        pedidoEntrada = 1'b1; chaves = 16'h1234;
        tick(D + 3);
        s0 = strobes;
        for (int i = 0; i < 4; i++) begin
            botaoPlaca = (i % 2 == 0);
            tick(1);
        end
        chk("bounce_no_early_strobe", strobes - s0, 32'd0);
        press(8, 8);
        chk("bounce_one_strobe", strobes - s0, 32'd1);
        chk("bounce_dado", {16'd0, dadoEntrada}, 32'h1234);
        pedidoEntrada = 1'b0;
        tick(3);

        // Press without a request is discarded.
        s0 = strobes; chaves = 16'h0F0F;
        press(8, 10);
        pedidoEntrada = 1'b1;
        tick(10);
        chk("idle_press_dropped", strobes - s0, 32'd0);
        chk("idle_wait_aguardando", {31'd0, aguardando}, 32'h1);
        chk("idle_wait_pausa", {31'd0, pausa}, 32'h1);
        press(10, 6);
        chk("idle_then_press", strobes - s0, 32'd1);
        pedidoEntrada = 1'b0;
        tick(3);

        // Button held when the request rises: needs release then new press.
        s0 = strobes;
        botaoPlaca = 1'b1;
        tick(10);
        pedidoEntrada = 1'b1;
        tick(10);
        chk("held_no_strobe", strobes - s0, 32'd0);
        chk("held_aguardando", {31'd0, aguardando}, 32'h1);
        botaoPlaca = 1'b0; chaves = 16'hBEEF;
        tick(D + 4);
        press(10, 6);
        chk("held_then_fresh", strobes - s0, 32'd1);
        chk("held_dado", {16'd0, dadoEntrada}, 32'hBEEF);
        pedidoEntrada = 1'b0;
        tick(3);

        // Request held high after delivery cannot consume a second press.
        pedidoEntrada = 1'b1; chaves = 16'h7E57;
        tick(D + 3);
        press(10, 8);
        s0 = strobes;
        press(10, 8);
        chk("held_request_no_second", strobes - s0, 32'd0);
        chk("fim_aguardando", {31'd0, aguardando}, 32'h0);
        pedidoEntrada = 1'b0;
        tick(1);
        pedidoEntrada = 1'b1;
        tick(3);
        chk("rearm_aguardando", {31'd0, aguardando}, 32'h1);
        press(10, 6);
        chk("rearm_delivers", strobes - s0, 32'd1);
        pedidoEntrada = 1'b0;
        tick(3);

        // Reset with debounce half counted aborts the transaction.
        pedidoEntrada = 1'b1; chaves = 16'h5555;
        tick(D + 3);
        s0 = strobes;
        botaoPlaca = 1'b1;
        tick(4);
        reset = 1'b1; botaoPlaca = 1'b0;
        tick(1);
        reset = 1'b0;
        #1;
        chk("midreset_dado", {16'd0, dadoEntrada}, 32'h0);
        chk("midreset_pronta", {31'd0, entradaPronta}, 32'h0);
        tick(12);
        chk("midreset_no_strobe", strobes - s0, 32'd0);
        pedidoEntrada = 1'b0;
        tick(3);

        // Random traffic: glitches, presses, request toggles, rare resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) botaoPlaca = ~botaoPlaca;
            if ($urandom_range(0, 24) == 0) pedidoEntrada = ~pedidoEntrada;
            chaves = W'($urandom);
            reset  = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
